// File: rtl/pin_entry_ctrl_if.sv
// Keypad-to-lock bundle: key strobes and lockout in, PIN bus, enter strobe and status out.
interface pin_entry_ctrl_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        locked;
  logic [15:0] inpin;
  logic        enter;
  logic [2:0]  digit_cnt;
  logic        busy;
  logic        err;

  // Keypad / lock side that drives keys and observes the PIN controller
  modport master (
    output key_valid, key_code, locked,
    input  inpin, enter, digit_cnt, busy, err
  );

  // PIN entry controller side
  modport slave (
    input  key_valid, key_code, locked,
    output inpin, enter, digit_cnt, busy, err
  );
endinterface

// File: rtl/pin_entry_ctrl.sv
// PIN entry front end: buffers up to four BCD digits, handles backspace,
// clear and inter-key timeout, and on a full-length enter presents the PIN on
// inpin one cycle ahead of a single-cycle, flop-driven enter strobe. inpin is
// only ever written on the enter-key edge, so it is stable around the strobe.
module pin_entry_ctrl #(
  parameter int TIMEOUT = 5000,
  parameter int GUARD   = 8,
  parameter int TW      = 16
) (
  input logic            clk,
  input logic            rstn,
  pin_entry_ctrl_if.slave kp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_LOAD,
    S_STROBE,
    S_GUARD
  } state_t;

  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] GD_LAST = TW'(GUARD - 1);
  localparam logic [TW-1:0] TMR_ONE = TW'(1);
  localparam logic [3:0]    K_BKSP  = 4'hA;
  localparam logic [3:0]    K_CLR   = 4'hB;
  localparam logic [3:0]    K_ENTER = 4'hC;

  state_t          state_reg, state_next;
  logic [15:0]     pin_buf_reg, pin_buf_next;
  logic [2:0]      cnt_reg, cnt_next;
  logic [15:0]     inpin_reg, inpin_next;
  logic            enter_reg, enter_next;
  logic            err_reg, err_next;
  logic [TW-1:0]   tmr_reg, tmr_next;
  logic            is_digit;

  // Next-state and datapath decode; the timer is shared between the
  // inter-key timeout (counts up) and the post-strobe guard (counts down).
  // Only accepted keys restart the timeout: an ignored digit at four digits
  // or a 0xD-0xF code counts as an idle cycle.
  always_comb begin
    state_next   = state_reg;
    pin_buf_next = pin_buf_reg;
    cnt_next     = cnt_reg;
    inpin_next   = inpin_reg;
    tmr_next     = tmr_reg;
    enter_next   = 1'b0;
    err_next     = 1'b0;
    is_digit     = (kp.key_code <= 4'd9);

    case (state_reg)
      S_IDLE, S_ENTRY: begin
        if (kp.locked) begin
          pin_buf_next = '0;
          cnt_next     = '0;
          tmr_next     = '0;
          state_next   = S_IDLE;
        end else if (kp.key_valid && is_digit && cnt_reg != 3'd4) begin
          pin_buf_next = {pin_buf_reg[11:0], kp.key_code};
          cnt_next     = cnt_reg + 3'd1;
          tmr_next     = '0;
          state_next   = S_ENTRY;
        end else if (kp.key_valid && kp.key_code == K_BKSP && cnt_reg != 3'd0) begin
          pin_buf_next = {4'h0, pin_buf_reg[15:4]};
          cnt_next     = cnt_reg - 3'd1;
          tmr_next     = '0;
          state_next   = (cnt_reg == 3'd1) ? S_IDLE : S_ENTRY;
        end else if (kp.key_valid && kp.key_code == K_CLR) begin
          pin_buf_next = '0;
          cnt_next     = '0;
          tmr_next     = '0;
          state_next   = S_IDLE;
        end else if (kp.key_valid && kp.key_code == K_ENTER) begin
          tmr_next = '0;
          if (cnt_reg == 3'd4) begin
            inpin_next = pin_buf_reg;
            state_next = S_LOAD;
          end else begin
            err_next     = 1'b1;
            pin_buf_next = '0;
            cnt_next     = '0;
            state_next   = S_IDLE;
          end
        end else if (state_reg == S_ENTRY) begin
          if (tmr_reg == TO_LAST) begin
            err_next     = 1'b1;
            pin_buf_next = '0;
            cnt_next     = '0;
            tmr_next     = '0;
            state_next   = S_IDLE;
          end else begin
            tmr_next = tmr_reg + TMR_ONE;
          end
        end
      end
      S_LOAD: begin
        enter_next = 1'b1;
        state_next = S_STROBE;
      end
      S_STROBE: begin
        pin_buf_next = '0;
        cnt_next     = '0;
        tmr_next     = GD_LAST;
        state_next   = S_GUARD;
      end
      S_GUARD: begin
        if (tmr_reg == '0) begin
          state_next = S_IDLE;
        end else begin
          tmr_next = tmr_reg - TMR_ONE;
        end
      end
      default: begin
        state_next   = S_IDLE;
        pin_buf_next = '0;
        cnt_next     = '0;
        tmr_next     = '0;
      end
    endcase
  end

  // State and datapath registers; reset clears everything, including the strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= S_IDLE;
      pin_buf_reg <= '0;
      cnt_reg     <= '0;
      inpin_reg   <= '0;
      enter_reg   <= 1'b0;
      err_reg     <= 1'b0;
      tmr_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      pin_buf_reg <= pin_buf_next;
      cnt_reg     <= cnt_next;
      inpin_reg   <= inpin_next;
      enter_reg   <= enter_next;
      err_reg     <= err_next;
      tmr_reg     <= tmr_next;
    end
  end

  assign kp.inpin     = inpin_reg;
  assign kp.enter     = enter_reg;
  assign kp.digit_cnt = cnt_reg;
  assign kp.err       = err_reg;
  assign kp.busy      = (state_reg == S_STROBE) || (state_reg == S_GUARD);

endmodule
